// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load-data formatter and writeback select.
// Keeps the one-cycle data_memory word alive across WB stalls via a small hold FSM.
module mem_wb_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  MEM_valid_i,
    input  logic                  MEM_RegWrite_i,
    input  logic                  MEM_MemRead_i,
    input  logic [1:0]            MEM_wb_sel_i,
    input  logic [2:0]            MEM_funct3_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
    input  logic [REG_ADDR_W-1:0] MEM_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  WB_valid_o,
    output logic                  WB_RegWrite_o,
    output logic [REG_ADDR_W-1:0] WB_rd_addr_o,
    output logic [DATA_WIDTH-1:0] WB_wb_data_o,
    output logic                  WB_load_misalign_o
);

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic {
        FRESH = 1'b0,
        HELD  = 1'b1
    } hold_state_e;

    hold_state_e state_q, state_d;

    logic                  valid_q;
    logic                  regwrite_q;
    logic                  memread_q;
    logic [1:0]            wb_sel_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] pc4_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_WIDTH-1:0] hold_q;

    logic                  wb_load;
    logic                  hold_load;
    logic [DATA_WIDTH-1:0] load_word;
    logic [1:0]            off;
    logic [BYTE_W-1:0]     byte_sel;
    logic [HALF_W-1:0]     half_sel;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  misalign;

    assign wb_load = valid_q & memread_q;
    assign off     = alu_q[1:0];

    // WB pipeline register; flush wins over stall and only needs to kill the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            wb_sel_q   <= 2'd0;
            funct3_q   <= 3'd0;
            alu_q      <= '0;
            pc4_q      <= '0;
            rd_q       <= '0;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q    <= MEM_valid_i;
            regwrite_q <= MEM_RegWrite_i;
            memread_q  <= MEM_MemRead_i;
            wb_sel_q   <= MEM_wb_sel_i;
            funct3_q   <= MEM_funct3_i;
            alu_q      <= MEM_alu_result_i;
            pc4_q      <= MEM_pc_plus4_i;
            rd_q       <= MEM_rd_addr_i;
        end
    end

    // Load-hold state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FRESH;
        end else begin
            state_q <= state_d;
        end
    end

    // Load-hold next state: only a stalled WB load moves to HELD
    always_comb begin
        state_d = state_q;
        if (flush_i || !stall_i) begin
            state_d = FRESH;
        end else if (state_q == FRESH && wb_load) begin
            state_d = HELD;
        end
    end

    // Load-hold outputs: word source and snapshot enable
    always_comb begin
        load_word = mem_rd_data_i;
        hold_load = 1'b0;
        case (state_q)
            FRESH: begin
                load_word = mem_rd_data_i;
                hold_load = stall_i & ~flush_i & wb_load;
            end
            HELD: begin
                load_word = hold_q;
                hold_load = 1'b0;
            end
            default: begin
                load_word = mem_rd_data_i;
                hold_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (hold_load) begin
            hold_q <= mem_rd_data_i;
        end
    end

    assign byte_sel = load_word[{off, 3'b000} +: BYTE_W];
    assign half_sel = load_word[{off[1], 4'b0000} +: HALF_W];

    // Load extraction; unknown funct3 passes the full word through
    always_comb begin
        load_ext = load_word;
        case (funct3_q)
            FUNCT3_LB:  load_ext = {{(DATA_WIDTH-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            FUNCT3_LBU: load_ext = {{(DATA_WIDTH-BYTE_W){1'b0}}, byte_sel};
            FUNCT3_LH:  load_ext = {{(DATA_WIDTH-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            FUNCT3_LHU: load_ext = {{(DATA_WIDTH-HALF_W){1'b0}}, half_sel};
            FUNCT3_LW:  load_ext = load_word;
            default:    load_ext = load_word;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        if (wb_load) begin
            case (funct3_q)
                FUNCT3_LH, FUNCT3_LHU: misalign = off[0];
                FUNCT3_LW:             misalign = (off != 2'd0);
                default:               misalign = 1'b0;
            endcase
        end
    end

    // Writeback select; reserved encoding falls back to the ALU result
    always_comb begin
        WB_wb_data_o = alu_q;
        case (wb_sel_q)
            WB_SEL_MEM: WB_wb_data_o = load_ext;
            WB_SEL_PC4: WB_wb_data_o = pc4_q;
            default:    WB_wb_data_o = alu_q;
        endcase
    end

    assign WB_valid_o         = valid_q;
    assign WB_rd_addr_o       = rd_q;
    assign WB_load_misalign_o = misalign;
    assign WB_RegWrite_o      = valid_q & regwrite_q & ~misalign & (rd_q != '0);

endmodule
